cr_huf_comp_htb_seq_merge: RTL



---
 rtl/cr_huf_comp_htb_seq_merge.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cr_huf_comp_htb_seq_merge.sv
// rtl/cr_huf_comp_htb_seq_merge.sv - merges ht1/ht2 build-completion records back into seq_id order
// Per-pipe FIFOs feed one output register; a stall timeout resynchronises expected_seq.
module cr_huf_comp_htb_seq_merge #(
  parameter int SEQID_W    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p1_vld,
  input  logic [SEQID_W-1:0] p1_seq_id,
  input  logic               p1_build_error,
  input  logic               p1_zero_symbols,
  output logic               p1_not_ready,
  input  logic               p2_vld,
  input  logic [SEQID_W-1:0] p2_seq_id,
  input  logic               p2_build_error,
  input  logic               p2_zero_symbols,
  output logic               p2_not_ready,
  input  logic               sw_disable_second_pipe,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [SEQID_W-1:0] out_seq_id,
  output logic               out_build_error,
  output logic               out_zero_symbols,
  output logic               out_pipe_sel,
  output logic               seq_err,
  output logic               seq_resync
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = SEQID_W + 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [9:0] TMO_LIM = 10'(TIMEOUT);
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_RESYNC = 1'b1;

  // Record layout: {build_error, zero_symbols, seq_id}; index 0 = pipe1, 1 = pipe2.
  logic [RW-1:0]      mem [2][FIFO_DEPTH];
  logic [AW-1:0]      wp [2];
  logic [AW-1:0]      rp [2];
  logic [AW:0]        cnt [2];
  logic [AW:0]        cnt_nxt [2];
  logic [RW-1:0]      in_rec [2];
  logic [RW-1:0]      head [2];
  logic [1:0]         in_vld, push, pop, empty, nr_q;
  logic [SEQID_W-1:0] exp_seq, hseq1, hseq2, d1, d2, rs_tgt;
  logic [RW-1:0]      win_rec;
  logic               m1, m2, load;
  logic [0:0]         state;
  logic [9:0]         tmo;

  assign in_vld    = {p2_vld, p1_vld};
  assign in_rec[0] = {p1_build_error, p1_zero_symbols, p1_seq_id};
  assign in_rec[1] = {p2_build_error, p2_zero_symbols, p2_seq_id};
  assign push      = in_vld & ~nr_q;
  assign head[0]   = mem[0][rp[0]];
  assign head[1]   = mem[1][rp[1]];
  assign empty[0]  = (cnt[0] == '0);
  assign empty[1]  = (cnt[1] == '0);
  assign p1_not_ready = nr_q[0];
  assign p2_not_ready = nr_q[1];

  assign hseq1 = head[0][SEQID_W-1:0];
  assign hseq2 = head[1][SEQID_W-1:0];
  assign m1    = !empty[0] && (sw_disable_second_pipe || hseq1 == exp_seq);
  assign m2    = !sw_disable_second_pipe && !empty[1] && (hseq2 == exp_seq);
  assign load  = (state == ST_RUN) && (m1 || m2) && (!out_vld || out_rdy);
  assign pop   = {load && !m1 && m2, load && m1};
  assign win_rec = m1 ? head[0] : head[1];

  // Resync picks the head closest ahead of the stale expected_seq (modular distance).
  assign d1 = hseq1 - exp_seq;
  assign d2 = hseq2 - exp_seq;
  assign rs_tgt = (!empty[0] && !empty[1]) ? ((d2 < d1) ? hseq2 : hseq1)
                                           : (!empty[0] ? hseq1 : hseq2);
  assign seq_resync = (state == ST_RESYNC);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_nxt[i] = cnt[i];
      if (push[i] && !pop[i])
        cnt_nxt[i] = cnt[i] + 1'b1;
      else if (!push[i] && pop[i])
        cnt_nxt[i] = cnt[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i])
        mem[i][wp[i]] <= in_rec[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
      nr_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wp[i] <= wp[i] + 1'b1;
        if (pop[i])  rp[i] <= rp[i] + 1'b1;
        cnt[i]  <= cnt_nxt[i];
        nr_q[i] <= (cnt_nxt[i] == FULL_CNT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld          <= 1'b0;
      out_seq_id       <= '0;
      out_build_error  <= 1'b0;
      out_zero_symbols <= 1'b0;
      out_pipe_sel     <= 1'b0;
      exp_seq          <= '0;
      tmo              <= '0;
      state            <= ST_RUN;
      seq_err          <= 1'b0;
    end else begin
      if (load) begin
        out_vld          <= 1'b1;
        out_build_error  <= win_rec[RW-1];
        out_zero_symbols <= win_rec[RW-2];
        out_seq_id       <= win_rec[SEQID_W-1:0];
        out_pipe_sel     <= !m1;
        exp_seq          <= win_rec[SEQID_W-1:0] + 1'b1;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
      case (state)
        ST_RUN: begin
          if (m1 && m2)
            seq_err <= 1'b1;
          if (m1 || m2 || (empty == 2'b11)) begin
            tmo <= '0;
          end else begin
            tmo <= tmo + 10'd1;
            if (tmo + 10'd1 == TMO_LIM)
              state <= ST_RESYNC;
          end
        end
        ST_RESYNC: begin
          seq_err <= 1'b1;
          tmo     <= '0;
          exp_seq <= rs_tgt;
          state   <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
